// File: rtl/ap2_arith_pkg.sv
// Shared constants and elaboration helpers for the AP2 arithmetic maps.
package ap2_arith_pkg;

   // Default carry-chain segment length in bits.
   localparam int unsigned SegDefault = 8;

   // Number of carry-chain segments (and pipeline stages) for a given width.
   function automatic int unsigned nseg(input int unsigned width, input int unsigned seg);
      return (seg == 0) ? 0 : width / seg;
   endfunction

   // Legal segmentation: at least 2 bits per segment, whole segments only.
   function automatic bit seg_cfg_ok(input int unsigned width, input int unsigned seg);
      return (seg >= 2) && (width >= seg) && ((width % seg) == 0);
   endfunction

endpackage

// File: rtl/ap2_adder_seg.sv
// One combinational carry-chain segment: SEG full-adder cells in ripple.
// Also exposes the carry into the segment MSB so the caller can form signed overflow.
module ap2_adder_seg
   import ap2_arith_pkg::*;
#(
   parameter int unsigned SEG = SegDefault
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           ci,
   output logic [SEG-1:0] s,
   output logic           co,
   output logic           c_msb
);

   logic [SEG:0] c;

   // Ripple through one full-adder cell per bit.
   always_comb begin
      s    = '0;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < SEG; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign co    = c[SEG];
   assign c_msb = c[SEG-1];

endmodule

// File: rtl/ap2_pipe_adder.sv
// Pipelined wide add/subtract: the carry chain is cut every SEG bits by a register.
// Operands skew forward so segment k is added in stage k; finished sum bits are
// carried along unchanged so the whole result leaves the last stage together.
module ap2_pipe_adder
   import ap2_arith_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SEG   = SegDefault
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bi,
   input  logic             ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             co,
   output logic             ovf
);

   localparam int unsigned NSEG = nseg(WIDTH, SEG);

   if (!seg_cfg_ok(WIDTH, SEG)) begin : g_bad_cfg
      $error("ap2_pipe_adder: WIDTH must be a non-zero multiple of SEG and SEG >= 2");
   end

   // rdy[k]: stage k may load this edge; rdy[NSEG] is the consumer.
   logic [NSEG:0]    rdy;
   logic [WIDTH-1:0] b_eff;
   logic             ovf_q;

   assign b_eff     = bi ? ~b : b;
   assign rdy[NSEG] = out_ready;
   assign in_ready  = rdy[0];

   for (genvar k = 0; k < NSEG; k++) begin : g_stage
      logic             v_q;
      logic             c_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] y_q;

      logic             src_v;
      logic             src_c;
      logic [WIDTH-1:0] src_a;
      logic [WIDTH-1:0] src_b;
      logic [WIDTH-1:0] src_y;
      logic [WIDTH-1:0] y_d;
      logic [SEG-1:0]   seg_s;
      logic             seg_co;
      logic             seg_cmsb;

      if (k == 0) begin : g_src
         assign src_v = in_valid;
         assign src_c = ci;
         assign src_a = a;
         assign src_b = b_eff;
         assign src_y = '0;
      end else begin : g_src
         assign src_v = g_stage[k-1].v_q;
         assign src_c = g_stage[k-1].c_q;
         assign src_a = g_stage[k-1].a_q;
         assign src_b = g_stage[k-1].b_q;
         assign src_y = g_stage[k-1].y_q;
      end

      // A stage can take new data if it is empty or its successor is draining.
      assign rdy[k] = !v_q || rdy[k+1];

      ap2_adder_seg #(
         .SEG (SEG)
      ) u_seg (
         .a     (src_a[k*SEG +: SEG]),
         .b     (src_b[k*SEG +: SEG]),
         .ci    (src_c),
         .s     (seg_s),
         .co    (seg_co),
         .c_msb (seg_cmsb)
      );

      // Drop this segment's sum into the partially built result word.
      always_comb begin
         y_d                = src_y;
         y_d[k*SEG +: SEG]  = seg_s;
      end

      // Stage register: loads whenever the stage is ready, otherwise holds.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            y_q <= '0;
         end else if (rdy[k]) begin
            v_q <= src_v;
            c_q <= seg_co;
            a_q <= src_a;
            b_q <= src_b;
            y_q <= y_d;
         end
      end

      if (k == NSEG - 1) begin : g_last
         // Signed overflow from the carries into and out of the MSB.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (rdy[k]) begin
               ovf_q <= seg_cmsb ^ seg_co;
            end
         end
      end
   end

   assign out_valid = g_stage[NSEG-1].v_q;
   assign y         = g_stage[NSEG-1].y_q;
   assign co        = g_stage[NSEG-1].c_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_ap2_pipe_adder.sv
// Self-checking bench for ap2_pipe_adder (WIDTH=32, SEG=8): directed vectors,
// random streaming, backpressure and mid-flight reset against a queue model.
module tb_ap2_pipe_adder;

   typedef struct {
      logic [31:0] y;
      logic        co;
      logic        ovf;
      int          acc;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        bi;
      logic        ci;
      logic [31:0] y;
      logic        co;
      logic        ovf;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        bi;
   logic        ci;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] y;
   logic        co;
   logic        ovf;

   int          n_pass;
   int          n_total;
   int          cyc;
   int          n_acc;
   int          n_pop;
   bit          lat_check;
   bit          popped;
   bit          last_in_ready;
   logic [31:0] got_y;
   logic        got_co;
   logic        got_ovf;
   exp_t        q[$];
   vec_t        vecs[10];

   int          acc0;
   int          pop0;
   int          drops;
   int          unstable;
   int          stale;
   bit          have_snap;
   logic [31:0] snap_y;
   logic        snap_co;
   logic        snap_ovf;

   ap2_pipe_adder #(
      .WIDTH (32),
      .SEG   (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bi        (bi),
      .ci        (ci),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .co        (co),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input bit ok, input string got, input string exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %s, expected %s", name, got, exp);
   endtask

   // Reference: plain 33-bit arithmetic; overflow when like-signed operands give
   // a result of the other sign.
   function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                  input logic mbi, input logic mci);
      exp_t        e;
      logic [31:0] be;
      logic [32:0] s;
      be    = mbi ? ~mb : mb;
      s     = {1'b0, ma} + {1'b0, be} + {32'd0, mci};
      e.y   = s[31:0];
      e.co  = s[32];
      e.ovf = (ma[31] == be[31]) && (s[31] != ma[31]);
      e.acc = 0;
      return e;
   endfunction

   // Called at a falling edge with inputs set; samples, scores, advances one clock.
   task automatic cycle();
      exp_t e;
      #1;
      last_in_ready = in_ready;
      popped        = 1'b0;
      if (out_valid && out_ready) begin
         popped  = 1'b1;
         got_y   = y;
         got_co  = co;
         got_ovf = ovf;
         n_pop++;
         if (q.size() == 0) begin
            check("unexpected_out", 1'b0, $sformatf("y=%h", y), "no result pending");
         end else begin
            e = q.pop_front();
            check("model", (y === e.y) && (co === e.co) && (ovf === e.ovf) &&
                           (!lat_check || (cyc - e.acc == 4)),
                  $sformatf("y=%h co=%b ovf=%b lat=%0d", y, co, ovf, cyc - e.acc),
                  $sformatf("y=%h co=%b ovf=%b lat=4", e.y, e.co, e.ovf));
         end
      end
      if (in_valid && in_ready && rst_n) begin
         e     = model(a, b, bi, ci);
         e.acc = cyc;
         q.push_back(e);
         n_acc++;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int a0;
      a0       = n_acc;
      a        = v.a;
      b        = v.b;
      bi       = v.bi;
      ci       = v.ci;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      if (n_acc != a0 + 1) check({name, "_accept"}, 1'b0, "not accepted", "accepted");
      for (int i = 0; i < 12 && !popped; i++) cycle();
      if (!popped) begin
         check({name, "_timeout"}, 1'b0, "no out_valid", "result within 12 cycles");
      end else begin
         check(name, (got_y === v.y) && (got_co === v.co) && (got_ovf === v.ovf),
               $sformatf("y=%h co=%b ovf=%b", got_y, got_co, got_ovf),
               $sformatf("y=%h co=%b ovf=%b", v.y, v.co, v.ovf));
      end
   endtask

   task automatic drain(input int limit);
      in_valid = 1'b0;
      for (int i = 0; i < limit && q.size() > 0; i++) cycle();
   endtask

   initial begin
      n_pass = 0; n_total = 0; cyc = 0; n_acc = 0; n_pop = 0;
      lat_check = 1'b1;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; bi = 1'b0; ci = 1'b0;

      vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
      vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      vecs[7] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vecs[8] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
      vecs[9] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};

      // Reset state.
      @(negedge clk);
      #1;
      check("rst_out_valid", out_valid === 1'b0, $sformatf("%b", out_valid), "0");
      check("rst_y", y === 32'd0, $sformatf("%h", y), "00000000");
      check("rst_co", co === 1'b0, $sformatf("%b", co), "0");
      check("rst_ovf", ovf === 1'b0, $sformatf("%b", ovf), "0");
      check("rst_in_ready", in_ready === 1'b1, $sformatf("%b", in_ready), "1");
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;

      // Directed vectors, one at a time, latency checked by the model path.
      for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Streaming: 100 back-to-back random operands.
      drops = 0;
      pop0  = n_pop;
      for (int i = 0; i < 100; i++) begin
         a = $urandom(); b = $urandom();
         bi = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
         in_valid = 1'b1;
         cycle();
         if (!last_in_ready) drops++;
      end
      drain(20);
      check("stream_in_ready", drops == 0, $sformatf("%0d drops", drops), "0 drops");
      check("stream_count", (n_pop - pop0 == 100) && (q.size() == 0),
            $sformatf("%0d results, %0d pending", n_pop - pop0, q.size()), "100 results, 0 pending");

      // Backpressure: consumer stalled for 10 cycles while pushing.
      lat_check = 1'b0;
      out_ready = 1'b0;
      acc0      = n_acc;
      pop0      = n_pop;
      unstable  = 0;
      have_snap = 1'b0;
      for (int i = 0; i < 10; i++) begin
         a = $urandom(); b = $urandom();
         bi = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
         in_valid = 1'b1;
         cycle();
         if (out_valid) begin
            if (have_snap && ((y !== snap_y) || (co !== snap_co) || (ovf !== snap_ovf)))
               unstable++;
            have_snap = 1'b1;
            snap_y = y; snap_co = co; snap_ovf = ovf;
         end
      end
      #1;
      check("bp_accepts", n_acc - acc0 == 4, $sformatf("%0d", n_acc - acc0), "4");
      check("bp_in_ready_low", in_ready === 1'b0, $sformatf("%b", in_ready), "0");
      check("bp_stable", (unstable == 0) && have_snap,
            $sformatf("%0d changes, held=%b", unstable, have_snap), "0 changes, held=1");
      // Full pipe: pop and push on the same edge keeps in_ready high.
      out_ready = 1'b1;
      a = $urandom(); b = $urandom(); bi = 1'b0; ci = 1'b1;
      #1;
      check("full_pop_push_ready", in_ready === 1'b1, $sformatf("%b", in_ready), "1");
      cycle();
      drain(30);
      check("bp_release", (n_pop - pop0 == 5) && (q.size() == 0),
            $sformatf("%0d results, %0d pending", n_pop - pop0, q.size()), "5 results, 0 pending");

      // Reset with three entries in flight.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = 32'h0101_0101 * (i + 1); b = 32'h00F0_F0F1; bi = 1'b0; ci = 1'b1;
         in_valid = 1'b1;
         cycle();
      end
      in_valid = 1'b0;
      cycle();
      check("pre_rst_out_valid", out_valid === 1'b1, $sformatf("%b", out_valid), "1");
      rst_n = 1'b0;
      #1;
      check("mid_rst_out", (out_valid === 1'b0) && (y === 32'd0) && (co === 1'b0) &&
                           (ovf === 1'b0),
            $sformatf("v=%b y=%h co=%b ovf=%b", out_valid, y, co, ovf), "v=0 y=00000000 co=0 ovf=0");
      check("mid_rst_in_ready", in_ready === 1'b1, $sformatf("%b", in_ready), "1");
      q.delete();
      cycle();
      cycle();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      stale     = 0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (out_valid) stale++;
      end
      check("no_stale", stale == 0, $sformatf("%0d", stale), "0");
      lat_check = 1'b1;
      run_vec(vecs[2], "post_rst_vec");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
